// File: rtl/hova_seq_pkg.sv
// Shared state type and sizing helpers for the Hovalaag instruction sequencer.
package hova_seq_pkg;
   typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_PAUSE} seq_state_t;

   localparam int DEF_STAGES    = 10;
   localparam int DEF_PC_STAGE  = 7;
   localparam int DEF_OUT_STAGE = 0;
   localparam int STAGE_W       = 4;

   function automatic int nchunk(input int instr_w, input int chunk_w);
      return (instr_w + chunk_w - 1) / chunk_w;
   endfunction
endpackage

// File: rtl/hova_instr_rom.sv
// Writable instruction store: one write port, one registered read port.
module hova_instr_rom
   import hova_seq_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int ROM_AW  = 3
) (
   input  logic               clk12MHz,
   input  logic               reset_n,
   input  logic               i_we,
   input  logic [ROM_AW-1:0]  i_waddr,
   input  logic [INSTR_W-1:0] i_wdata,
   input  logic               i_re,
   input  logic [ROM_AW-1:0]  i_raddr,
   output logic [INSTR_W-1:0] o_rdata
);
   logic [INSTR_W-1:0] r_mem [2**ROM_AW];
   logic [INSTR_W-1:0] r_rdata;

   // Contents survive reset; only the fetched word is cleared.
   always_ff @(posedge clk12MHz) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk12MHz) begin
      if (!reset_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/hova_sequencer.sv
// Feeds ROM instructions to a chunk-fed Hovalaag CPU on a divided clock and
// tracks its PC/output, with run/halt/step control and a PC breakpoint.
module hova_sequencer
   import hova_seq_pkg::*;
#(
   parameter int DIV_BITS     = 19,
   parameter int INSTR_W      = 32,
   parameter int CHUNK_W      = 6,
   parameter int STAGES       = DEF_STAGES,
   parameter int PC_W         = 8,
   parameter int ROM_AW       = 3,
   parameter int RESET_CYCLES = 20,
   parameter int PC_STAGE     = DEF_PC_STAGE,
   parameter int OUT_STAGE    = DEF_OUT_STAGE
) (
   input  logic               clk12MHz,
   input  logic               reset_n,
   input  logic [PC_W-1:0]    dut_out,
   output logic               dut_clk,
   output logic               dut_rst_n,
   output logic [CHUNK_W-1:0] dut_data,
   input  logic               rom_we,
   input  logic [ROM_AW-1:0]  rom_waddr,
   input  logic [INSTR_W-1:0] rom_wdata,
   input  logic               go,
   input  logic               halt,
   input  logic               step,
   input  logic               bp_en,
   input  logic [PC_W-1:0]    bp_addr,
   output logic [PC_W-1:0]    pc,
   output logic [3:0]         stage,
   output logic [PC_W-1:0]    out_data,
   output logic               out_valid,
   output logic               paused,
   output logic               bp_hit
);
   localparam int NCHUNK = nchunk(INSTR_W, CHUNK_W);
   localparam int PAD_W  = NCHUNK * CHUNK_W;
   localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

   localparam logic [STAGE_W-1:0]  LAST_STAGE = STAGE_W'(STAGES - 1);
   localparam logic [STAGE_W-1:0]  PC_ST      = STAGE_W'(PC_STAGE);
   localparam logic [STAGE_W-1:0]  OUT_ST     = STAGE_W'(OUT_STAGE);
   localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [DIV_BITS-1:0] RISE_CNT   = {1'b0, {(DIV_BITS-1){1'b1}}};
   localparam logic [DIV_BITS-1:0] FALL_CNT   = '1;

   seq_state_t          r_state;
   logic [DIV_BITS-1:0] r_div_cnt;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [STAGE_W-1:0]  r_stage;
   logic [PC_W-1:0]     r_pc;
   logic [PC_W-1:0]     r_out_data;
   logic                r_out_valid;
   logic                r_paused;
   logic                r_bp_hit;
   logic                r_bp_pending;
   logic                r_halt_pending;
   logic                r_step_active;
   logic [CHUNK_W-1:0]  r_dut_data;

   logic                w_rise;
   logic                w_fall;
   logic                w_fetch;
   logic                w_bp_match;
   logic                w_bp_now;
   logic [INSTR_W-1:0]  w_instr;
   logic [PAD_W-1:0]    w_pad;
   logic [CHUNK_W-1:0]  w_chunk;

   assign w_rise     = (r_div_cnt == RISE_CNT);
   assign w_fall     = (r_div_cnt == FALL_CNT);
   assign w_fetch    = w_rise && (((r_state == ST_RUN) && (r_stage == LAST_STAGE)) ||
                                  ((r_state == ST_HOLD) && (r_hold_cnt == HOLD_LAST)));
   assign w_bp_match = bp_en && (dut_out == bp_addr);
   // Covers a breakpoint sampled in the very boundary stage.
   assign w_bp_now   = r_bp_pending || ((r_stage == PC_ST) && w_bp_match);

   hova_instr_rom #(.INSTR_W(INSTR_W), .ROM_AW(ROM_AW)) u_rom (
      .clk12MHz (clk12MHz),
      .reset_n  (reset_n),
      .i_we     (rom_we),
      .i_waddr  (rom_waddr),
      .i_wdata  (rom_wdata),
      .i_re     (w_fetch),
      .i_raddr  (r_pc[ROM_AW-1:0]),
      .o_rdata  (w_instr)
   );

   assign w_pad = PAD_W'(w_instr);

   always_comb begin
      w_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (r_stage == STAGE_W'(i)) w_chunk = w_pad[i*CHUNK_W +: CHUNK_W];
      end
   end

   always_ff @(posedge clk12MHz) begin
      if (!reset_n) begin
         r_state        <= ST_HOLD;
         r_div_cnt      <= '0;
         r_hold_cnt     <= '0;
         r_stage        <= '0;
         r_pc           <= '0;
         r_out_data     <= '0;
         r_out_valid    <= 1'b0;
         r_paused       <= 1'b0;
         r_bp_hit       <= 1'b0;
         r_bp_pending   <= 1'b0;
         r_halt_pending <= 1'b0;
         r_step_active  <= 1'b0;
         r_dut_data     <= '0;
      end else begin
         r_out_valid <= 1'b0;
         if (r_state != ST_PAUSE) r_div_cnt <= r_div_cnt + 1'b1;
         case (r_state)
            ST_HOLD: begin
               if (w_rise) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
                  if (r_hold_cnt == HOLD_LAST) begin
                     r_state <= ST_RUN;
                     r_stage <= '0;
                  end
               end
            end
            ST_RUN: begin
               if (halt)    r_halt_pending <= 1'b1;
               else if (go) r_halt_pending <= 1'b0;
               if (w_rise) r_stage <= (r_stage == LAST_STAGE) ? '0 : r_stage + 1'b1;
               if (w_fall) begin
                  r_dut_data <= w_chunk;
                  if (r_stage == PC_ST) begin
                     r_pc <= dut_out;
                     if (w_bp_match) r_bp_pending <= 1'b1;
                  end
                  if (r_stage == OUT_ST) begin
                     r_out_data  <= dut_out;
                     r_out_valid <= 1'b1;
                  end
                  if ((r_stage == LAST_STAGE) && (r_halt_pending || w_bp_now || r_step_active)) begin
                     r_state        <= ST_PAUSE;
                     r_paused       <= 1'b1;
                     r_bp_hit       <= w_bp_now;
                     r_halt_pending <= 1'b0;
                     r_bp_pending   <= 1'b0;
                     r_step_active  <= 1'b0;
                  end
               end
            end
            ST_PAUSE: begin
               if (go && !halt) begin
                  r_state  <= ST_RUN;
                  r_paused <= 1'b0;
                  r_bp_hit <= 1'b0;
               end else if (step) begin
                  r_state       <= ST_RUN;
                  r_paused      <= 1'b0;
                  r_bp_hit      <= 1'b0;
                  r_step_active <= 1'b1;
               end
            end
            default: r_state <= ST_HOLD;
         endcase
      end
   end

   assign dut_clk   = r_div_cnt[DIV_BITS-1];
   assign dut_rst_n = (r_state != ST_HOLD);
   assign dut_data  = (r_state == ST_HOLD) ? CHUNK_W'(1) : r_dut_data;
   assign pc        = r_pc;
   assign stage     = r_stage;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign paused    = r_paused;
   assign bp_hit    = r_bp_hit;
endmodule
